prime_stream_ctrl: RTL and testbench
====================================

# prime_stream_ctrl

Sequencer for the 54-entry prime lookup datapath. Index 0 maps to prime 2 and index 53 maps to prime 251; out-of-range indices read 0. On a start command the block walks the table from a programmed first index for a programmed count. It streams each prime out over a valid/ready handshake with one-cycle latency, then signals completion. It also flags an error when a request runs past the end of the table.

## Interface
Parameters:
- IDX_W, 6, index width
- DATA_W, 8, prime/data width
- MAX_IDX, 53, last valid table index

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  start command; sampled only in IDLE
- first_idx_i  in  IDX_W  first table index, captured on accepted start
- count_i  in  IDX_W  number of primes to emit, captured on accepted start (0 = none)
- abort_i  in  1  terminate the current stream
- data_o  out  DATA_W  current prime (registered)
- valid_o  out  1  data_o holds an unconsumed prime
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky: stream ran past MAX_IDX; cleared by the next accepted start

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers: idx (IDX_W), remaining (IDX_W).
- IDLE with start_i=1 (accepted start): err_o<=0, then exactly one of the following:
  - count_i==0: go to DONE; no data is emitted.
  - first_idx_i>MAX_IDX: err_o<=1; go to DONE; no data is emitted.
  - Otherwise: data_o<=prime(first_idx_i), valid_o<=1, idx<=first_idx_i+1, remaining<=count_i-1; go to RUN.
- RUN, processed in priority order:
  - abort_i=1: valid_o<=0; go to DONE. err_o is unchanged. abort_i overrides a same-cycle handshake; that beat counts as not consumed.
  - Handshake with remaining==0: valid_o<=0; go to DONE.
  - Handshake with idx>MAX_IDX: valid_o<=0, err_o<=1; go to DONE.
  - Handshake otherwise: data_o<=prime(idx), idx++, remaining--, valid_o stays 1.
  - No handshake: data_o, valid_o, idx and remaining hold.
- DONE: done_o=1 for exactly this cycle; go to IDLE. start_i is ignored here.
- start_i in RUN or DONE is ignored and is not queued. abort_i in IDLE or DONE has no effect.
- Width and arithmetic rules:
  - idx never exceeds MAX_IDX+1, so there is no wrap.
  - remaining never underflows: the decrement happens only when remaining>0.
- Reset, including mid-stream: state=IDLE; valid_o, busy_o, done_o, err_o all 0; data_o=0; idx and remaining 0. Outputs change immediately on rst_n falling, not on the next clock edge.

## Timing
- Latency: the first valid_o is asserted in the cycle after the accepted start edge.
- Throughput: one prime per cycle while ready_i is held high.
- Handshake stability: while valid_o && !ready_i, data_o and valid_o are stable. valid_o never drops without a handshake, except on abort or reset.
- done_o asserts in the cycle after the final handshake, abort, or zero-length/error start. busy_o deasserts in the cycle after done_o.
- Minimum start-to-start spacing is 2 cycles: a start edge, then DONE, then IDLE. A start can be accepted in the cycle after done_o.
- No combinational paths from inputs to outputs; all outputs are registered.

## Structure
- Shared package prime_pkg holds:
  - IDX_W, DATA_W, MAX_IDX
  - the state enum (IDLE, RUN, DONE)
  - the 54-entry prime constant table
- Sub-module prime_rom: purely combinational, idx to prime, returns 0 for idx>MAX_IDX. The controller instantiates it once and drives its address from a mux between first_idx_i (in IDLE) and idx (in RUN).
- Controller FSM plus datapath registers live in prime_stream_ctrl; no other sub-modules.

## Test plan
- Basic stream: first=0, count=5, ready_i=1 → data_o 2,3,5,7,11 on 5 consecutive cycles starting start+1; done_o at start+6; err_o=0.
- Table overrun: first=50, count=8, ready_i=1 → data_o 233,239,241,251, then valid_o=0, done_o pulse, err_o=1 held until the next start.
- Backpressure: first=10, count=3, ready_i low for 3 cycles then toggling 1/0 → 31 held stable until accepted, then 37, 41; no drops or duplicates; done_o after the 41 handshake.
- Degenerate starts:
  - count=0 → no valid_o; done_o at start+1; err_o=0.
  - first=60, count=2 → no valid_o; done_o at start+1; err_o=1.
- Abort and ignored start: first=20, count=10; assert abort_i with ready_i=1 after 73,79 are accepted → 83 is not consumed, valid_o drops, done_o next cycle. A start_i pulsed mid-stream has no effect.
- Async reset: assert rst_n=0 mid-stream between clock edges → valid_o, busy_o, err_o go to 0 immediately. After release, a start with first=53, count=1 yields 251 then done_o, err_o=0.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared widths, FSM state type and the prime constant table for the prime streamer.
package prime_pkg;

  localparam int unsigned IDX_W     = 6;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MAX_IDX   = 53;
  localparam int unsigned N_ENTRIES = MAX_IDX + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The first 54 primes; entry 53 (251) is the largest prime that fits in DATA_W bits.
  localparam logic [DATA_W-1:0] PRIME_TABLE [N_ENTRIES] = '{
    8'd2,   8'd3,   8'd5,   8'd7,   8'd11,  8'd13,  8'd17,  8'd19,  8'd23,  8'd29,
    8'd31,  8'd37,  8'd41,  8'd43,  8'd47,  8'd53,  8'd59,  8'd61,  8'd67,  8'd71,
    8'd73,  8'd79,  8'd83,  8'd89,  8'd97,  8'd101, 8'd103, 8'd107, 8'd109, 8'd113,
    8'd127, 8'd131, 8'd137, 8'd139, 8'd149, 8'd151, 8'd157, 8'd163, 8'd167, 8'd173,
    8'd179, 8'd181, 8'd191, 8'd193, 8'd197, 8'd199, 8'd211, 8'd223, 8'd227, 8'd229,
    8'd233, 8'd239, 8'd241, 8'd251
  };

endpackage

// File: rtl/prime_rom.sv
// Combinational prime lookup: index to prime, zero for indices past the end of the table.
module prime_rom
  import prime_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] prime_c_o
);

  // Guarded table read; out-of-range addresses return 0.
  always_comb begin
    prime_c_o = '0;
    if (idx_i <= IDX_W'(MAX_IDX)) begin
      prime_c_o = PRIME_TABLE[idx_i];
    end
  end

endmodule

// File: rtl/prime_stream_ctrl.sv
// Walks the prime table from a programmed index for a programmed count, streaming
// each prime over valid/ready, pulsing done at the end and flagging table overruns.
module prime_stream_ctrl
  import prime_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  first_idx_i,
  input  logic [IDX_W-1:0]  count_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    rom_addr_c;
  logic [DATA_W-1:0]   rom_data_c;
  logic                hs_c;

  // ROM address: the requested first index while idle, the walking index while streaming.
  assign rom_addr_c = (state_q == IDLE) ? first_idx_i : idx_q;
  assign hs_c       = valid_q && ready_i;

  prime_rom u_rom (
    .idx_i     (rom_addr_c),
    .prime_c_o (rom_data_c)
  );

  // Next-state and datapath updates; abort outranks a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (count_i == '0) begin
            state_d = DONE;
          end else if (first_idx_i > IDX_W'(MAX_IDX)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d  = rom_data_c;
            valid_d = 1'b1;
            idx_d   = first_idx_i + IDX_W'(1);
            rem_d   = count_i - IDX_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (hs_c) begin
          if (rem_q == '0) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (idx_q > IDX_W'(MAX_IDX)) begin
            valid_d = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            data_d = rom_data_c;
            idx_d  = idx_q + IDX_W'(1);
            rem_d  = rem_q - IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_prime_stream_ctrl.sv
// Directed vector bench for prime_stream_ctrl: a per-edge table plus async reset sequences.
module tb_prime_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [5:0] first_idx_i;
  logic [5:0] count_i;
  logic       abort_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic [5:0] first;
    logic [5:0] cnt;
    logic       abort;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  prime_stream_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .first_idx_i (first_idx_i),
    .count_i     (count_i),
    .abort_i     (abort_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  task automatic chk_outs(input int id, input logic ev, input logic [7:0] ed,
                          input logic eb, input logic edn, input logic ee);
    chk("valid_o", id, 32'(valid_o), 32'(ev));
    if (ev) chk("data_o", id, 32'(data_o), 32'(ed));
    chk("busy_o", id, 32'(busy_o), 32'(eb));
    chk("done_o", id, 32'(done_o), 32'(edn));
    chk("err_o", id, 32'(err_o), 32'(ee));
  endtask

  task automatic add(input logic st, input int fi, input int cn, input logic ab, input logic rd,
                     input logic ev, input int ed, input logic eb, input logic edn, input logic ee);
    vec_t v;
    v.start = st; v.first = 6'(fi); v.cnt = 6'(cn); v.abort = ab; v.ready = rd;
    v.exp_valid = ev; v.exp_data = 8'(ed); v.exp_busy = eb; v.exp_done = edn; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; first_idx_i = '0; count_i = '0; abort_i = 1'b0; ready_i = 1'b0;

    // Each row: inputs held across one rising edge, outputs expected just after it.
    // Basic stream 0..4
    add(1, 0, 5, 0, 1,  1,   2, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,   3, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,   5, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,   7, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,  11, 1, 0, 0);
    add(0, 0, 0, 0, 1,  0,   0, 1, 1, 0);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 0);
    // Abort while idle does nothing
    add(0, 0, 0, 1, 1,  0,   0, 0, 0, 0);
    // Zero count, then a start during DONE is dropped
    add(1, 7, 0, 0, 1,  0,   0, 1, 1, 0);
    add(1, 0, 3, 0, 1,  0,   0, 0, 0, 0);
    // Out-of-range first index
    add(1, 60, 2, 0, 1, 0,   0, 1, 1, 1);
    add(0, 0, 0, 0, 0,  0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0,   0, 0, 0, 1);
    // Table overrun from 50 for 8
    add(1, 50, 8, 0, 1, 1, 233, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 239, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 241, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 251, 1, 0, 0);
    add(0, 0, 0, 0, 1,  0,   0, 1, 1, 1);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 1);
    // Backpressure from 10 for 3
    add(1, 10, 3, 0, 0, 1,  31, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1,  31, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1,  31, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1,  31, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,  37, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1,  37, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,  41, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1,  41, 1, 0, 0);
    add(0, 0, 0, 0, 1,  0,   0, 1, 1, 0);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 0);
    // Abort from 20 for 10 with an ignored mid-stream start
    add(1, 20, 10, 0, 1, 1, 73, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1,  79, 1, 0, 0);
    add(1, 0, 1, 0, 1,  1,  83, 1, 0, 0);
    add(0, 0, 0, 1, 1,  0,   0, 1, 1, 0);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  0,   0, 0, 0, 0);

    // Reset state
    #12;
    chk_outs(-1, 0, 0, 0, 0, 0);
    chk("data_o reset", -1, 32'(data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_i = vecs[i].start; first_idx_i = vecs[i].first; count_i = vecs[i].cnt;
      abort_i = vecs[i].abort; ready_i = vecs[i].ready;
      step();
      chk_outs(i, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_busy,
               vecs[i].exp_done, vecs[i].exp_err);
    end
    start_i = 1'b0; abort_i = 1'b0;

    // Sticky error cleared asynchronously by reset
    start_i = 1'b1; first_idx_i = 6'd63; count_i = 6'd1; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_outs(100, 0, 0, 1, 1, 1);
    step();
    chk_outs(101, 0, 0, 0, 0, 1);
    #3 rst_n = 1'b0;
    #1 chk("err_o async reset", 102, 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream async reset between edges
    start_i = 1'b1; first_idx_i = 6'd0; count_i = 6'd5; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_outs(110, 1, 2, 1, 0, 0);
    step();
    chk_outs(111, 1, 3, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk_outs(112, 0, 0, 0, 0, 0);
    chk("data_o async reset", 112, 32'(data_o), 32'd0);
    step();
    chk_outs(113, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Last table entry, single beat
    start_i = 1'b1; first_idx_i = 6'd53; count_i = 6'd1; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    chk_outs(120, 1, 251, 1, 0, 0);
    step();
    chk_outs(121, 0, 0, 1, 1, 0);
    step();
    chk_outs(122, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
